// File: rtl/round_pack.sv
// round_pack: two-stage IEEE-754 single-precision round-and-pack pipeline (S1 round, S2 pack/output).
// Define ROUND_MODES_EN to honour rm (RTZ/RUP/RDN); otherwise RNE is always used and rm is ignored.
module round_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [7:0]  Er_norm,
  input  logic [23:0] Mr_norm,
  input  logic [2:0]  GRS_norm,
  input  logic        overflow,
  input  logic [1:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf_flag,
  output logic        inexact
);
  logic        s1_valid_q, s1_sign_q, s1_ovf_q, s1_sat_q, s1_inx_q;
  logic [7:0]  s1_exp_q;
  logic [22:0] s1_frac_q;
  logic        s2_valid_q, s2_ready;
  logic [31:0] result_q, result_d;
  logic        ovf_q, inx_q;
  logic        rne_inc, inc, sat_d, ovf_d;
  logic [24:0] sum;
  logic [7:0]  exp_d;
  logic [22:0] frac_d;

  assign rne_inc = GRS_norm[2] & (GRS_norm[1] | GRS_norm[0] | Mr_norm[0]);
`ifdef ROUND_MODES_EN
  // RUP rounds up positives, RDN rounds up negatives; sat selects max-finite on overflow
  assign inc   = rm == 2'b00 ? rne_inc : rm == 2'b01 ? 1'b0 : (|GRS_norm) & (sign == rm[0]);
  assign sat_d = (rm == 2'b01) | (rm[1] & (sign != rm[0]));
`else
  logic unused_rm;
  assign unused_rm = ^rm;
  assign inc       = rne_inc;
  assign sat_d     = 1'b0;
`endif
  assign sum    = {1'b0, Mr_norm} + {24'd0, inc};
  assign frac_d = sum[24] ? sum[23:1] : sum[22:0];
  assign exp_d  = sum[24] ? Er_norm + 8'd1 : (Er_norm == 8'd0 && sum[23]) ? 8'd1 : Er_norm;
  assign ovf_d  = overflow | (exp_d == 8'hFF);

  assign s2_ready  = ~s2_valid_q | out_ready;
  assign in_ready  = ~s1_valid_q | s2_ready;
  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign ovf_flag  = ovf_q;
  assign inexact   = inx_q;

  assign result_d = !s1_ovf_q ? {s1_sign_q, s1_exp_q, s1_frac_q} :
                    s1_sat_q  ? {s1_sign_q, 8'hFE, 23'h7FFFFF} : {s1_sign_q, 8'hFF, 23'h0};

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_sign_q <= sign;
      s1_exp_q  <= exp_d;
      s1_frac_q <= frac_d;
      s1_ovf_q  <= ovf_d;
      s1_sat_q  <= sat_d;
      s1_inx_q  <= (|GRS_norm) | ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= 32'd0;
      ovf_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (s2_ready) s2_valid_q <= s1_valid_q;
      if (s2_ready && s1_valid_q) begin
        result_q <= result_d;
        ovf_q    <= s1_ovf_q;
        inx_q    <= s1_inx_q;
      end
    end
  end
endmodule
